// File: rtl/wave_pkg.sv
// Shared types for the waveform step controller.
//   wave_mode_e       : waveform shape selected at configuration time
//   wave_ctrl_state_e : controller FSM states
//   cnt_width()       : width of the count feedback bus for a given terminal count
package wave_pkg;

    typedef enum logic [1:0] {
        SAW_UP = 2'd0,
        SAW_DN = 2'd1,
        TRI    = 2'd2,
        HOLD   = 2'd3
    } wave_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wave_ctrl_state_e;

    // The feedback bus must be able to carry the terminal count itself, so it is
    // sized for max_val+1 codes (identical to $clog2(max_val) for non-powers of two).
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/wave_tick_div.sv
// Step-rate divider: while enabled, tick_o is high once every period_i+1 cycles,
// first on the cycle where the internal count reaches period_i after a clear.
//   clk_i, reset_ni : clock, synchronous active-low reset
//   clr_i           : zero the divider (takes priority over en_i)
//   en_i            : advance the divider and allow ticks
//   period_i        : terminal value of the divider
//   tick_o          : combinational step strobe
module wave_tick_div #(
    parameter int div_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [div_width_p-1:0] period_i,
    output logic                   tick_o
);

    logic [div_width_p-1:0] div_q, div_d;

    assign tick_o = en_i && (div_q == period_i);

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = tick_o ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/wave_step_ctrl.sv
// Waveform step controller: drives an external up/down wave counter with step
// pulses to produce saw-up, saw-down, triangle or hold patterns for a configured
// number of waveform periods (0 = run until stopped).
//   clk_i, reset_ni          : clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o  : configuration handshake (ready only in IDLE)
//   cfg_mode_i/period_i/cycles_i : mode, step period-1, waveform periods to run
//   stop_i                   : abort the current run
//   count_i                  : wave counter value fed back
//   up_o, down_o             : step pulses to the counter
//   busy_o, done_o           : activity flag, one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | waiting for a configuration handshake
// ST_RUN  | stepping the counter on divider ticks
// ST_DONE | one-cycle completion pulse, then back to IDLE
module wave_step_ctrl
    import wave_pkg::*;
#(
    parameter int max_val_p   = 15,
    parameter int div_width_p = 16,
    parameter int cyc_width_p = 8,
    localparam int CntW       = wave_pkg::cnt_width(max_val_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [1:0]             cfg_mode_i,
    input  logic [div_width_p-1:0] cfg_period_i,
    input  logic [cyc_width_p-1:0] cfg_cycles_i,
    input  logic                   stop_i,
    input  logic [CntW-1:0]        count_i,
    output logic                   up_o,
    output logic                   down_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [CntW-1:0]        CntMax = CntW'(max_val_p);
    localparam logic [CntW-1:0]        CntOne = CntW'(1);
    localparam logic [cyc_width_p-1:0] CycOne = cyc_width_p'(1);

    wave_ctrl_state_e       state_q, state_d;
    wave_mode_e             mode_q, mode_d;
    logic [div_width_p-1:0] period_q, period_d;
    logic [cyc_width_p-1:0] cycles_q, cycles_d;
    logic [cyc_width_p-1:0] completed_q, completed_d;
    logic                   dir_up_q, dir_up_d;

    logic tick, div_clr, div_en;
    logic up, down, complete;

    assign div_en = (state_q == ST_RUN);

    wave_tick_div #(
        .div_width_p (div_width_p)
    ) u_div (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (div_clr),
        .en_i     (div_en),
        .period_i (period_q),
        .tick_o   (tick)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        period_d    = period_q;
        cycles_d    = cycles_q;
        completed_d = completed_q;
        dir_up_d    = dir_up_q;
        up          = 1'b0;
        down        = 1'b0;
        complete    = 1'b0;
        div_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    mode_d      = wave_mode_e'(cfg_mode_i);
                    period_d    = cfg_period_i;
                    cycles_d    = cfg_cycles_i;
                    completed_d = '0;
                    dir_up_d    = 1'b1;
                    div_clr     = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    case (mode_q)
                        SAW_UP: begin
                            up       = 1'b1;
                            complete = (count_i == CntMax);
                        end
                        SAW_DN: begin
                            down     = 1'b1;
                            complete = (count_i == '0);
                        end
                        TRI: begin
                            if (dir_up_q) begin
                                if (count_i == CntMax) begin
                                    dir_up_d = 1'b0;
                                    down     = 1'b1;
                                end else begin
                                    up = 1'b1;
                                end
                            end else begin
                                if (count_i == '0) begin
                                    dir_up_d = 1'b1;
                                    up       = 1'b1;
                                end else begin
                                    down     = 1'b1;
                                    // Next step lands on zero: the period is closed.
                                    complete = (count_i == CntOne);
                                end
                            end
                        end
                        default: ;
                    endcase

                    if (complete) begin
                        if ((cycles_q != '0) && ((completed_q + CycOne) == cycles_q)) begin
                            state_d = ST_DONE;
                        end else if (completed_q != '1) begin
                            completed_d = completed_q + CycOne;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            mode_q      <= SAW_UP;
            period_q    <= '0;
            cycles_q    <= '0;
            completed_q <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            cycles_q    <= cycles_d;
            completed_q <= completed_d;
            dir_up_q    <= dir_up_d;
        end
    end

    // Outputs are gated with reset so they read 0 while reset is held, even
    // before the first clock edge has returned the state to IDLE.
    assign cfg_ready_o = (state_q == ST_IDLE) && reset_ni;
    assign up_o        = up && reset_ni;
    assign down_o      = down && reset_ni;
    assign busy_o      = (state_q != ST_IDLE) && reset_ni;
    assign done_o      = (state_q == ST_DONE) && reset_ni;

endmodule

// File: doc/wave_step_ctrl.md
WAVE_STEP_CTRL -- requirements
Module: wave_step_ctrl

Interface
REQ-001 SHALL have parameter max_val_p, default 15; terminal count of the driven wave_counter (legal values are 1 or greater).
REQ-002 SHALL have parameter div_width_p, default 16; width of the tick-period field.
REQ-003 SHALL have parameter cyc_width_p, default 8; width of the waveform-repeat field.
REQ-004 clk_i  in  1  sole clock; all state updates on posedge.
REQ-005 reset_ni  in  1  synchronous, active-low reset.
REQ-006 cfg_valid_i  in  1  configuration offer.
REQ-007 cfg_ready_o  out  1  configuration accepted this cycle when high with cfg_valid_i.
REQ-008 cfg_mode_i  in  2  0 saw-up, 1 saw-down, 2 triangle, 3 hold.
REQ-009 cfg_period_i  in  div_width_p  step pulse every cfg_period_i+1 cycles.
REQ-010 cfg_cycles_i  in  cyc_width_p  waveform periods to run; 0 means unlimited.
REQ-011 stop_i  in  1  abort request.
REQ-012 count_i  in  $clog2(max_val_p)  current count fed back from the wave counter.
REQ-013 up_o / down_o  out  1 each  step pulses to the counter.
REQ-014 busy_o  out  1  high when not IDLE; done_o  out  1  single-cycle completion pulse.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 cfg_ready_o SHALL equal (state==IDLE) and reset_ni; handshakes in RUN or DONE are ignored.
REQ-017 On handshake, SHALL latch mode, period and cycles, clear the divider and period counters, set triangle direction to up, and go to RUN.
REQ-018 Divider in RUN: tick = (div_q==period_q); on tick div_q<=0, otherwise div_q<=div_q+1; first tick falls period_q cycles after RUN entry.
REQ-019 Saw-up: up_o=tick; a period completes on a tick with count_i==max_val_p.
REQ-020 Saw-down: down_o=tick; a period completes on a tick with count_i==0.
REQ-021 Triangle, direction up: tick at count_i==max_val_p flips direction to down and issues down_o; otherwise issues up_o.
REQ-022 Triangle, direction down: tick at count_i==0 flips direction to up and issues up_o; otherwise issues down_o; a period completes on a down_o tick with count_i==1.
REQ-023 Hold: up_o and down_o SHALL stay 0; RUN exits only on stop_i.
REQ-024 On a completing tick, the pulse SHALL still be issued; if cycles_q!=0 and completed+1==cycles_q, next state is DONE; otherwise the completed count increments, saturating at its maximum when cycles_q==0.
REQ-025 stop_i in RUN SHALL suppress that cycle's pulse and force DONE next cycle; stop_i in IDLE or DONE is ignored.
REQ-026 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-027 up_o and down_o SHALL be combinational, only high in RUN, and never high together.

Reset
REQ-028 With reset_ni low at a clock edge: state IDLE, div_q=0, completed count=0, direction up, latched fields=0.
REQ-029 During reset, up_o, down_o, busy_o, done_o and cfg_ready_o SHALL be 0; reset mid-RUN SHALL produce no done_o.

Structure
REQ-030 The shared package wave_pkg SHALL hold the wave_mode_e enum (SAW_UP, SAW_DN, TRI, HOLD) and the wave_ctrl_state_e enum.
REQ-031 The divider SHALL be a sub-module, wave_tick_div (clear, enable, period in; tick out).
REQ-032 The block SHALL contain no count register; it drives an external wave_counter through up_o/down_o.

Verification (max_val_p=3, with a wave_counter in the loop)
REQ-033 Saw-up, period=1, cycles=2, count starts at 0 -> 8 up_o pulses 2 cycles apart, count sequence 1,2,3,0,1,2,3,0, then one done_o, then cfg_ready_o=1.
REQ-034 Triangle, period=0, cycles=1 -> pulses up,up,up,down,down,down on consecutive cycles, count returns to 0, then done_o.
REQ-035 Saw-down, period=3, cycles=0, stop_i asserted on a tick cycle -> no pulse that cycle, done_o next cycle, busy_o low the cycle after.
REQ-036 Hold, then stop_i after 20 cycles -> zero pulses, busy_o high throughout, single done_o.
REQ-037 reset_ni low mid-triangle -> next cycle all outputs 0 and state IDLE, no done_o; a new cfg restarts with direction up.
REQ-038 cfg_valid_i held high during RUN with a different mode -> no effect, cfg_ready_o 0; accepted in the first IDLE cycle after done_o.
